// File: rtl/icache_resp.sv
// Direct-mapped instruction cache that answers fetch lookups in the same cycle and
// refills a missing line word by word from the backing memory over req/ack.
module icache_resp #(
  parameter int LINES = 16,
  parameter int WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic [31:0] iaddr,
  input  logic        flush,
  output logic [31:0] idata,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_cnt,
  output logic [31:0] miss_cnt
);

  localparam int OFF  = $clog2(WORDS);
  localparam int IDX  = $clog2(LINES);
  localparam int TAGW = 32 - OFF - IDX - 2;

  // Handshake: mem_req stays high and mem_addr stays stable until a cycle with mem_ack=1;
  // that edge consumes mem_rdata for the word at mem_addr. mem_ack outside FILL is ignored.
  typedef enum logic {IDLE, FILL} state_e;

  state_e            state_q;
  logic [LINES-1:0]  valid_q;
  logic [TAGW-1:0]   tag_q  [LINES];
  logic [31:0]       data_q [LINES][WORDS];
  logic [IDX-1:0]    fill_idx_q;
  logic [TAGW-1:0]   fill_tag_q;
  logic [OFF-1:0]    cnt_q;
  logic              flushed_q;
  logic              mem_req_q;
  logic [31:0]       mem_addr_q;
  logic [31:0]       hit_cnt_q;
  logic [31:0]       miss_cnt_q;

  logic [IDX-1:0]    idx;
  logic [OFF-1:0]    off;
  logic [TAGW-1:0]   tag;
  logic              hit;
  logic              last_ack;
  logic              unused_addr_bits;

  assign idx              = iaddr[OFF+IDX+1:OFF+2];
  assign off              = iaddr[OFF+1:2];
  assign tag              = iaddr[31:OFF+IDX+2];
  assign unused_addr_bits = ^iaddr[1:0];

  assign hit      = !rst && (state_q == IDLE) && req && valid_q[idx] && (tag_q[idx] == tag);
  assign last_ack = (state_q == FILL) && mem_ack && (cnt_q == OFF'(WORDS - 1));

  assign idata    = hit ? data_q[idx][off] : 32'h0;
  assign stall    = !rst && ((state_q == FILL) || (req && !hit));
  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign hit_cnt  = hit_cnt_q;
  assign miss_cnt = miss_cnt_q;

  // Line storage carries no reset; valid_q alone decides whether contents are usable.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == FILL) && mem_ack) begin
      data_q[fill_idx_q][cnt_q] <= mem_rdata;
      if (cnt_q == OFF'(WORDS - 1)) tag_q[fill_idx_q] <= fill_tag_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fill_idx_q <= '0;
      fill_tag_q <= '0;
      cnt_q      <= '0;
      flushed_q  <= 1'b0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= 32'h0;
      hit_cnt_q  <= 32'h0;
      miss_cnt_q <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          flushed_q <= 1'b0;
          if (hit) begin
            hit_cnt_q <= hit_cnt_q + 32'd1;
          end else if (req) begin
            // The victim line goes invalid now so a half-written line can never hit.
            valid_q[idx] <= 1'b0;
            fill_idx_q   <= idx;
            fill_tag_q   <= tag;
            cnt_q        <= '0;
            mem_req_q    <= 1'b1;
            mem_addr_q   <= {iaddr[31:OFF+2], {(OFF+2){1'b0}}};
            miss_cnt_q   <= miss_cnt_q + 32'd1;
            state_q      <= FILL;
          end
        end
        FILL: begin
          if (flush) flushed_q <= 1'b1;
          if (mem_ack) begin
            cnt_q      <= cnt_q + 1'b1;
            mem_addr_q <= mem_addr_q + 32'd4;
          end
          if (last_ack) begin
            if (!flushed_q) valid_q[fill_idx_q] <= 1'b1;
            mem_req_q <= 1'b0;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
      // Flush outranks any valid set on the same edge.
      if (flush) valid_q <= '0;
    end
  end

endmodule
